game_tick_scheduler: RTL and testbench

Timing controller for the DDR game. It replaces free-running derived clocks with single-cycle enable pulses in the `i_clk` domain: a 25 MHz pixel enable, a 1 s tick and an arrow-movement tick. It also sequences the game through idle, countdown, run and pause, and speeds up the arrow movement as the level rises. It sits between the board clock and the VGA/arrow/score logic; every consumer runs on `i_clk` and qualifies its updates with these enables.

---
 rtl/game_tick_scheduler.sv | 107 ++++++++++
 tb/tb_game_tick_scheduler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: pixel/second/movement enables and idle-countdown-run-pause sequencing for the DDR game
module game_tick_scheduler #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned MOV_BASE_DIV = 1250000,
    parameter int unsigned MOV_STEP     = 62500,
    parameter int unsigned MOV_MIN_DIV  = 312500,
    parameter int unsigned LEVEL_SECS   = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_stop,
    output logic       o_pix_en,
    output logic       o_sec_tick,
    output logic       o_mov_tick,
    output logic [1:0] o_state,
    output logic [1:0] o_count,
    output logic [3:0] o_level
);
    typedef enum logic [1:0] {IDLE, CDOWN, RUN, PAUSE} state_t;
    state_t      state, state_n;
    logic [1:0]  pix_cnt, count, count_n;
    logic [3:0]  level, level_n;
    logic [31:0] sec_cnt, sec_cnt_n, mov_cnt, mov_cnt_n, per, per_n, lsec, lsec_n;
    logic        sec_tick, mov_tick;
    function automatic logic [31:0] period(input logic [3:0] lvl);
        return (32'(lvl) * MOV_STEP >= MOV_BASE_DIV - MOV_MIN_DIV) ? MOV_MIN_DIV : MOV_BASE_DIV - 32'(lvl) * MOV_STEP;
    endfunction
    assign sec_tick   = (state == CDOWN || state == RUN) && sec_cnt == CLK_HZ - 1;
    assign mov_tick   = state == RUN && mov_cnt == per - 1;
    assign o_sec_tick = sec_tick;
    assign o_mov_tick = mov_tick;
    assign o_state    = state;
    assign o_count    = count;
    assign o_level    = level;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            pix_cnt  <= 2'd0;
            o_pix_en <= 1'b0;
            count    <= 2'd0;
            level    <= 4'd0;
            sec_cnt  <= 32'd0;
            mov_cnt  <= 32'd0;
            per      <= MOV_BASE_DIV;
            lsec     <= 32'd0;
        end else begin
            state    <= state_n;
            pix_cnt  <= pix_cnt + 2'd1;
            o_pix_en <= pix_cnt == 2'd3;
            count    <= count_n;
            level    <= level_n;
            sec_cnt  <= sec_cnt_n;
            mov_cnt  <= mov_cnt_n;
            per      <= per_n;
            lsec     <= lsec_n;
        end
    end
    always_comb begin
        state_n   = state;
        count_n   = count;
        level_n   = level;
        sec_cnt_n = sec_cnt;
        mov_cnt_n = mov_cnt;
        per_n     = per;
        lsec_n    = lsec;
        if (i_stop) begin
            state_n   = IDLE;
            count_n   = 2'd0;
            level_n   = 4'd0;
            sec_cnt_n = 32'd0;
            mov_cnt_n = 32'd0;
            lsec_n    = 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = i_start ? CDOWN : IDLE;
                    count_n = i_start ? 2'd3 : count;
                end
                CDOWN: begin
                    sec_cnt_n = sec_tick ? 32'd0 : sec_cnt + 32'd1;
                    count_n   = sec_tick ? count - 2'd1 : count;
                    if (sec_tick && count == 2'd1) begin
                        state_n   = RUN;
                        level_n   = 4'd0;
                        lsec_n    = 32'd0;
                        per_n     = MOV_BASE_DIV;
                        mov_cnt_n = 32'd0;
                    end
                end
                RUN: begin
                    sec_cnt_n = sec_tick ? 32'd0 : sec_cnt + 32'd1;
                    mov_cnt_n = mov_tick ? 32'd0 : mov_cnt + 32'd1;
                    per_n     = mov_tick ? period(level) : per;
                    if (sec_tick) begin
                        lsec_n  = (lsec == LEVEL_SECS - 1) ? 32'd0 : lsec + 32'd1;
                        level_n = (lsec == LEVEL_SECS - 1 && level != 4'd15) ? level + 4'd1 : level;
                    end
                    state_n = i_pause ? PAUSE : RUN;
                end
                PAUSE: state_n = i_pause ? RUN : PAUSE;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: directed and random stimulus checked against a remaining-time reference model
module tb_game_tick_scheduler;
    localparam int HZ = 20, BASE = 8, STEP = 2, MINP = 3, LS = 2;
    logic       i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_pause = 1'b0, i_stop = 1'b0;
    logic       o_pix_en, o_sec_tick, o_mov_tick;
    logic [1:0] o_state, o_count;
    logic [3:0] o_level;
    int checks = 0, passes = 0, cyc = 0;
    int m_state, m_count, m_level, m_lsec, sec_left, mov_left, pix_edges;
    always #5 i_clk = ~i_clk;
    game_tick_scheduler #(
        .CLK_HZ(HZ), .MOV_BASE_DIV(BASE), .MOV_STEP(STEP), .MOV_MIN_DIV(MINP), .LEVEL_SECS(LS)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
        .o_pix_en(o_pix_en), .o_sec_tick(o_sec_tick), .o_mov_tick(o_mov_tick),
        .o_state(o_state), .o_count(o_count), .o_level(o_level)
    );
    function automatic int period(int lvl);
        int p = BASE - lvl * STEP;
        return p < MINP ? MINP : p;
    endfunction
    function automatic logic exp_sec();
        return (m_state == 1 || m_state == 2) && sec_left == 1;
    endfunction
    function automatic logic exp_mov();
        return m_state == 2 && mov_left == 1;
    endfunction
    function automatic logic [31:0] expv();
        logic pix = pix_edges > 0 && pix_edges % 4 == 0;
        return 32'({pix, exp_sec(), exp_mov(), 2'(m_state), 2'(m_count), 4'(m_level)});
    endfunction
    function automatic logic [31:0] obsv();
        return 32'({o_pix_en, o_sec_tick, o_mov_tick, o_state, o_count, o_level});
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask
    task automatic model_reset();
        m_state = 0; m_count = 0; m_level = 0; m_lsec = 0;
        sec_left = HZ; mov_left = BASE; pix_edges = 0;
    endtask
    task automatic advance(input logic s, input logic p, input logic t);
        logic es = exp_sec(), em = exp_mov();
        pix_edges++;
        if (t) begin
            m_state = 0; m_count = 0; m_level = 0; m_lsec = 0;
        end else if (m_state == 0) begin
            if (s) begin m_state = 1; m_count = 3; sec_left = HZ; end
        end else if (m_state == 1) begin
            if (es) begin
                sec_left = HZ;
                m_count--;
                if (m_count == 0) begin m_state = 2; m_level = 0; m_lsec = 0; mov_left = BASE; end
            end else sec_left--;
        end else if (m_state == 2) begin
            if (em) mov_left = period(m_level); else mov_left--;
            if (es) begin
                sec_left = HZ;
                m_lsec++;
                if (m_lsec == LS) begin m_lsec = 0; if (m_level < 15) m_level++; end
            end else sec_left--;
            if (p) m_state = 3;
        end else if (p) m_state = 2;
    endtask
    task automatic step(input logic s, input logic p, input logic t);
        i_start = s; i_pause = p; i_stop = t;
        chk("model", obsv(), expv());
        advance(s, p, t);
        @(posedge i_clk);
        #1;
        cyc++;
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
    endtask
    initial begin
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_outputs", obsv(), 32'd0);
        i_rst = 1'b0;
        repeat (40) step(0, 0, 0);
        chk("idle_state", 32'(o_state), 32'd0);
        step(1, 0, 0);
        repeat (19) step(0, 0, 0);
        chk("sec_tick_20", 32'(o_sec_tick), 32'd1);
        chk("count_at_20", 32'(o_count), 32'd3);
        repeat (20) step(0, 0, 0);
        chk("sec_tick_40", 32'(o_sec_tick), 32'd1);
        chk("count_at_40", 32'(o_count), 32'd2);
        repeat (20) step(0, 0, 0);
        chk("sec_tick_60", 32'(o_sec_tick), 32'd1);
        chk("count_at_60", 32'(o_count), 32'd1);
        step(0, 0, 0);
        chk("run_at_61", 32'(o_state), 32'd2);
        chk("count_run", 32'(o_count), 32'd0);
        repeat (200) step(0, 0, 0);
        chk("level_ge3", 32'(o_level >= 4'd3), 32'd1);
        repeat (500) step(0, 0, 0);
        chk("level_sat", 32'(o_level), 32'd15);
        step(0, 0, 1);
        step(1, 0, 0);
        repeat (60) step(0, 0, 0);
        chk("run_again", 32'(o_state), 32'd2);
        repeat (4) step(0, 0, 0);
        step(0, 1, 0);
        chk("paused", 32'(o_state), 32'd3);
        repeat (29) step(0, 0, 0);
        step(0, 1, 0);
        chk("resumed", 32'(o_state), 32'd2);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("mov_after_resume", 32'(o_mov_tick), 32'd1);
        repeat (30) step(0, 0, 0);
        step(0, 1, 1);
        chk("stop_state", 32'(o_state), 32'd0);
        chk("stop_level", 32'(o_level), 32'd0);
        repeat (30) step(0, 0, 0);
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        chk("cdown_before_rst", 32'(o_state), 32'd1);
        #2 i_rst = 1'b1;
        #1 chk("async_reset", obsv(), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        step(1, 0, 0);
        chk("restart_count", 32'(o_count), 32'd3);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3, $urandom_range(0, 999) < 3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
